// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the
// multi-channel programmable clock divider.
package clkdiv_pkg;

    localparam int CLK_HZ = 50_000_000;

    function automatic int ceillog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // channel-select width, never below one bit
    function automatic int ch_width(input int ch);
        return (ceillog2(ch) > 1) ? ceillog2(ch) : 1;
    endfunction

    // half-period in clk cycles for a wanted output frequency
    function automatic int hp_for(input int freq);
        return CLK_HZ / (2 * freq);
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with glitch-free
// half-period reload at period boundaries.
module clkdiv_chan #(
    parameter int CNT_W  = 26,
    parameter int DEF_HP = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_hp,
    output logic             clk_div,
    output logic             tick
);

    logic [CNT_W-1:0] hp;
    logic [CNT_W-1:0] pend;
    logic             pend_v;
    logic [CNT_W-1:0] cnt;
    logic             hp_zero;
    logic [CNT_W-1:0] hp_m1;
    logic             wrap;

    assign hp_zero = (hp == '0);
    assign hp_m1   = hp_zero ? '0 : hp - CNT_W'(1);
    assign wrap    = !hp_zero && (cnt == hp_m1);

    // counter, divided clock, tick and half-period reload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hp      <= CNT_W'(DEF_HP);
            pend    <= '0;
            pend_v  <= 1'b0;
            cnt     <= '0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else if (sync) begin
            cnt     <= '0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
            if (ld) begin
                hp     <= ld_hp;
                pend_v <= 1'b0;
            end else if (pend_v) begin
                hp     <= pend;
                pend_v <= 1'b0;
            end
        end else begin
            if (hp_zero) begin
                cnt     <= '0;
                clk_div <= 1'b0;
                tick    <= 1'b0;
                if (pend_v) begin
                    hp     <= pend;
                    pend_v <= 1'b0;
                end
            end else if (!en) begin
                tick <= 1'b0;
            end else if (wrap) begin
                cnt     <= '0;
                clk_div <= ~clk_div;
                tick    <= 1'b1;
                if (pend_v) begin
                    hp     <= pend;
                    pend_v <= 1'b0;
                end
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
            // a write on a wrap edge queues for the next wrap
            if (ld) begin
                pend   <= ld_hp;
                pend_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: CH programmable 50%-duty dividers sharing
// one half-period write port.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int CH     = 4,
    parameter int CNT_W  = 26,
    parameter int DEF_HP = 25_000_000,
    localparam int CH_W  = ch_width(CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_hp,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic [CH-1:0]    clk_div,
    output logic [CH-1:0]    tick
);

    logic cfg_ok;

    assign cfg_ok = ({{(32-CH_W){1'b0}}, cfg_ch} < CH);

    // write accept / reject strobes, one cycle after cfg_we
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_we && cfg_ok;
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic ld;

        assign ld = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));

        clkdiv_chan #(
            .CNT_W  (CNT_W),
            .DEF_HP (DEF_HP)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .sync    (sync),
            .ld      (ld),
            .ld_hp   (cfg_hp),
            .clk_div (clk_div[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: directed sequence with a per-cycle
// reference-model scoreboard plus fixed-edge checks.
module tb_clkdiv_multi;

    localparam int CH    = 3;
    localparam int CNT_W = 8;
    localparam int DEFH  = 5;

    logic             clk;
    logic             rst_n;
    logic [CH-1:0]    en;
    logic             sync;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_hp;
    logic             cfg_ack;
    logic             cfg_err;
    logic [CH-1:0]    clk_div;
    logic [CH-1:0]    tick;

    clkdiv_multi #(
        .CH     (CH),
        .CNT_W  (CNT_W),
        .DEF_HP (DEFH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_hp  (cfg_hp),
        .cfg_ack (cfg_ack),
        .cfg_err (cfg_err),
        .clk_div (clk_div),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] cd;
        logic [2:0] tk;
        logic       ack;
        logic       err;
    } exp_t;

    exp_t q[$];

    int n_assert = 0;
    int n_fail   = 0;

    int         m_hp[CH];
    int         m_pend[CH];
    int         m_cnt[CH];
    bit         m_pv[CH];
    logic [2:0] m_cd = '0;
    logic [2:0] m_tk = '0;
    logic       m_ack = 1'b0;
    logic       m_err = 1'b0;

    // reference behaviour for one clk edge using current inputs
    task automatic model_edge();
        bit ld;
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                m_hp[i]  = DEFH;
                m_pv[i]  = 1'b0;
                m_cnt[i] = 0;
            end
            m_cd  = '0;
            m_tk  = '0;
            m_ack = 1'b0;
            m_err = 1'b0;
            return;
        end
        m_ack = cfg_we && (int'(cfg_ch) < CH);
        m_err = cfg_we && (int'(cfg_ch) >= CH);
        for (int i = 0; i < CH; i++) begin
            ld = cfg_we && (int'(cfg_ch) == i);
            if (sync) begin
                m_cnt[i] = 0;
                m_cd[i]  = 1'b0;
                m_tk[i]  = 1'b0;
                if (ld) begin
                    m_hp[i] = int'(cfg_hp);
                    m_pv[i] = 1'b0;
                end else if (m_pv[i]) begin
                    m_hp[i] = m_pend[i];
                    m_pv[i] = 1'b0;
                end
            end else begin
                if (m_hp[i] == 0) begin
                    m_cnt[i] = 0;
                    m_cd[i]  = 1'b0;
                    m_tk[i]  = 1'b0;
                    if (m_pv[i]) begin
                        m_hp[i] = m_pend[i];
                        m_pv[i] = 1'b0;
                    end
                end else if (!en[i]) begin
                    m_tk[i] = 1'b0;
                end else if (m_cnt[i] + 1 == m_hp[i]) begin
                    m_cnt[i] = 0;
                    m_cd[i]  = !m_cd[i];
                    m_tk[i]  = 1'b1;
                    if (m_pv[i]) begin
                        m_hp[i] = m_pend[i];
                        m_pv[i] = 1'b0;
                    end
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                    m_tk[i]  = 1'b0;
                end
                if (ld) begin
                    m_pend[i] = int'(cfg_hp);
                    m_pv[i]   = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc();
        exp_t e;
        exp_t o;
        model_edge();
        q.push_back('{cd: m_cd, tk: m_tk, ack: m_ack, err: m_err});
        @(posedge clk);
        #1;
        e = q.pop_front();
        o = '{cd: clk_div, tk: tick, ack: cfg_ack, err: cfg_err};
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL model obs=%b exp=%b", o, e);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] hp);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_hp = hp;
    endtask

    task automatic wr_clr();
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_hp = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = '0;
        sync  = 1'b0;
        wr_clr();

        // reset state
        run(2);
        chk("rst_out", {clk_div, tick, cfg_ack, cfg_err}, 8'h00);

        // release, default half-period 5
        rst_n = 1'b1;
        en    = 3'b111;
        run(4);
        chk("e4_cd", {5'b0, clk_div}, 8'h00);
        cyc();
        chk("e5_cd", {5'b0, clk_div}, 8'h07);
        chk("e5_tk", {5'b0, tick}, 8'h07);
        cyc();
        chk("e6_tk", {5'b0, tick}, 8'h00);
        run(4);
        chk("e10_cd", {5'b0, clk_div}, 8'h00);
        chk("e10_tk", {5'b0, tick}, 8'h07);
        run(5);
        chk("e15_cd", {5'b0, clk_div}, 8'h07);

        // mid-run reset, then reprogram ch0 to 3 at edge 2
        rst_n = 1'b0;
        cyc();
        chk("rst2_out", {clk_div, tick, cfg_ack, cfg_err}, 8'h00);
        rst_n = 1'b1;
        cyc();
        wr(2'd0, 8'd3);
        cyc();
        wr_clr();
        chk("wr_ack", {6'b0, cfg_ack, cfg_err}, 8'h02);
        cyc();
        chk("wr_ack_off", {6'b0, cfg_ack, cfg_err}, 8'h00);
        run(2);
        chk("rp_e5_cd", {5'b0, clk_div}, 8'h07);
        run(3);
        chk("rp_e8", {4'b0, clk_div[1:0], tick[1:0]}, 8'h09);
        run(3);
        chk("rp_e11_cd0", {7'b0, clk_div[0]}, 8'h01);

        // hp=1: clk/2 with tick held high
        wr(2'd0, 8'd1);
        cyc();
        wr_clr();
        run(4);
        chk("hp1_e16", {6'b0, clk_div[0], tick[0]}, 8'h01);
        cyc();
        chk("hp1_e17", {6'b0, clk_div[0], tick[0]}, 8'h03);

        // hp=0: channel off
        wr(2'd0, 8'd0);
        cyc();
        wr_clr();
        run(3);
        chk("hp0", {6'b0, clk_div[0], tick[0]}, 8'h00);

        // en gating: ch0 back to 5, freeze at cnt=2
        wr(2'd0, 8'd5);
        cyc();
        wr_clr();
        run(3);
        en = 3'b110;
        run(4);
        chk("frz_tk0", {6'b0, clk_div[0], tick[0]}, 8'h00);
        en = 3'b111;
        run(2);
        chk("res_cd0", {7'b0, clk_div[0]}, 8'h00);
        cyc();
        chk("res_wrap0", {6'b0, clk_div[0], tick[0]}, 8'h03);

        // sync with simultaneous write ch1=7
        sync = 1'b1;
        wr(2'd1, 8'd7);
        cyc();
        sync = 1'b0;
        wr_clr();
        chk("sync_out", {clk_div, tick, cfg_ack, cfg_err}, 8'h02);
        run(6);
        chk("sync_e6_cd1", {7'b0, clk_div[1]}, 8'h00);
        cyc();
        chk("sync_e7_ch1", {6'b0, clk_div[1], tick[1]}, 8'h03);
        run(7);
        chk("sync_e14_ch1", {6'b0, clk_div[1], tick[1]}, 8'h01);

        // bad channel address
        wr(2'd3, 8'd2);
        cyc();
        wr_clr();
        chk("bad_err", {6'b0, cfg_ack, cfg_err}, 8'h01);
        cyc();
        chk("bad_err_off", {6'b0, cfg_ack, cfg_err}, 8'h00);
        run(12);

        // reset mid-run restores DEF_HP on every channel
        rst_n = 1'b0;
        cyc();
        chk("rst3_out", {clk_div, tick, cfg_ack, cfg_err}, 8'h00);
        rst_n = 1'b1;
        run(4);
        chk("rst3_e4_cd", {5'b0, clk_div}, 8'h00);
        cyc();
        chk("rst3_e5", {2'b0, clk_div, tick}, 8'h3f);
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
